pwm_multi_ctrl: RTL

PWM_MULTI_CTRL -- requirements
Module: pwm_multi_ctrl

---
 rtl/pwm_multi_ctrl_if.sv | 27 ++
 rtl/pwm_multi_ctrl.sv | 120 ++++++++++++
 2 files changed

// File: rtl/pwm_multi_ctrl_if.sv
// Control/status bundle for the multi-channel PWM controller.
interface pwm_multi_ctrl_if #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4
);
  localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                enable;
  logic                mode;
  logic [WIDTH-1:0]    period;
  logic                wr_en;
  logic [CH_W-1:0]     wr_ch;
  logic [WIDTH-1:0]    wr_duty;
  logic [CHANNELS-1:0] pwm_out;
  logic                cycle_start;
  logic [WIDTH-1:0]    counter_out;

  modport master (
    output enable, mode, period, wr_en, wr_ch, wr_duty,
    input  pwm_out, cycle_start, counter_out
  );

  modport slave (
    input  enable, mode, period, wr_en, wr_ch, wr_duty,
    output pwm_out, cycle_start, counter_out
  );
endinterface

// File: rtl/pwm_multi_ctrl.sv
// Multi-channel PWM generator: shared edge/center-aligned counter,
// per-channel shadow/active duty registers updated at period start.
module pwm_multi_ctrl #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4
) (
  input  logic            clk,
  input  logic            reset,
  pwm_multi_ctrl_if.slave bus
);

  localparam logic [0:0]       DIR_UP   = 1'b0;
  localparam logic [0:0]       DIR_DOWN = 1'b1;
  localparam logic [WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  logic [WIDTH-1:0]    counter;
  logic [0:0]          dir;
  logic [WIDTH-1:0]    shadow_duty [CHANNELS];
  logic [WIDTH-1:0]    active_duty [CHANNELS];
  logic [WIDTH-1:0]    active_period;
  logic                active_mode;
  logic [CHANNELS-1:0] pwm_q;
  logic                cycle_start_q;

  logic                period_start_c;
  logic [WIDTH-1:0]    eff_period_c;
  logic                eff_mode_c;
  logic                write_ok_c;
  logic [WIDTH-1:0]    counter_nxt;
  logic [0:0]          dir_nxt;
  logic [CHANNELS-1:0] pwm_nxt;

  // Period boundary and the values that govern the current cycle.
  assign period_start_c = bus.enable && (counter == CNT_ZERO) && (dir == DIR_UP);
  assign eff_period_c   = period_start_c ? bus.period : active_period;
  assign eff_mode_c     = period_start_c ? bus.mode   : active_mode;
  assign write_ok_c     = bus.wr_en && (32'(bus.wr_ch) < CHANNELS);

  // Next counter value and direction.
  always_comb begin
    counter_nxt = CNT_ZERO;
    dir_nxt     = DIR_UP;
    if (bus.enable) begin
      if (!eff_mode_c) begin
        counter_nxt = (counter >= eff_period_c) ? CNT_ZERO : counter + CNT_ONE;
      end else begin
        case (dir)
          DIR_UP: begin
            if (counter < eff_period_c) begin
              counter_nxt = counter + CNT_ONE;
            end else if (counter != CNT_ZERO) begin
              // Turn around at the top; a period of one returns straight to 0.
              counter_nxt = counter - CNT_ONE;
              dir_nxt     = (counter != CNT_ONE) ? DIR_DOWN : DIR_UP;
            end
          end
          default: begin
            counter_nxt = counter - CNT_ONE;
            dir_nxt     = (counter != CNT_ONE) ? DIR_DOWN : DIR_UP;
          end
        endcase
      end
    end
  end

  // Per-channel compare against the effective duty.
  always_comb begin
    pwm_nxt = '0;
    if (bus.enable) begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        pwm_nxt[i] = period_start_c ? (shadow_duty[i] > counter)
                                    : (active_duty[i] > counter);
      end
    end
  end

  // Counter, direction and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      counter       <= CNT_ZERO;
      dir           <= DIR_UP;
      pwm_q         <= '0;
      cycle_start_q <= 1'b0;
    end else begin
      counter       <= counter_nxt;
      dir           <= dir_nxt;
      pwm_q         <= pwm_nxt;
      cycle_start_q <= period_start_c;
    end
  end

  // Shadow writes and active-register latching at period start.
  always_ff @(posedge clk) begin
    if (reset) begin
      active_period <= '1;
      active_mode   <= 1'b0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        shadow_duty[i] <= CNT_ZERO;
        active_duty[i] <= CNT_ZERO;
      end
    end else begin
      if (period_start_c) begin
        active_period <= bus.period;
        active_mode   <= bus.mode;
        for (int i = 0; i < int'(CHANNELS); i++) begin
          active_duty[i] <= shadow_duty[i];
        end
      end
      if (write_ok_c) begin
        shadow_duty[bus.wr_ch] <= bus.wr_duty;
      end
    end
  end

  assign bus.pwm_out     = pwm_q;
  assign bus.cycle_start = cycle_start_q;
  assign bus.counter_out = counter;

endmodule
